// File: rtl/led_mem_resp.sv
// Single-port RAM responder for the LED memory controller: self-clears on reset, then serves 1-cycle reads/writes.
// Optional MEM_WRITE_FIRST_EN: writes also drive dina onto douta (write-first); otherwise douta holds on writes.
module led_mem_resp #(
  parameter int                DATA_W     = 16,
  parameter int                ADDR_W     = 4,
  parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
  input  logic              clk_g,
  input  logic              rst,
  input  logic              ena,
  input  logic              wea,
  input  logic [ADDR_W-1:0] addra,
  input  logic [DATA_W-1:0] dina,
  output logic [DATA_W-1:0] douta,
  output logic              busy,
  output logic              rd_valid
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {
    ST_INIT,
    ST_IDLE
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [ADDR_W-1:0]   ptr;
  logic [ADDR_W-1:0]   ptr_next;
  logic [DATA_W-1:0]   douta_next;
  logic                rd_valid_next;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   mem [0:DEPTH-1];

  // State, init pointer and output registers; memory itself is never reset
  always_ff @(posedge clk_g or posedge rst) begin
    if (rst) begin
      state    <= ST_INIT;
      ptr      <= '0;
      douta    <= '0;
      rd_valid <= 1'b0;
    end else begin
      state    <= state_next;
      ptr      <= ptr_next;
      douta    <= douta_next;
      rd_valid <= rd_valid_next;
    end
  end

  // Next-state and datapath control; requests are ignored entirely during INIT
  always_comb begin
    state_next    = state;
    ptr_next      = ptr;
    douta_next    = douta;
    rd_valid_next = 1'b0;
    mem_we        = 1'b0;
    mem_waddr     = ptr;
    mem_wdata     = INIT_VALUE;

    case (state)
      ST_INIT: begin
        mem_we    = 1'b1;
        mem_waddr = ptr;
        mem_wdata = INIT_VALUE;
        ptr_next  = ptr + ADDR_W'(1);
        if (&ptr) begin
          state_next = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (ena) begin
          if (wea) begin
            mem_we    = 1'b1;
            mem_waddr = addra;
            mem_wdata = dina;
`ifdef MEM_WRITE_FIRST_EN
            douta_next = dina;
`else
            douta_next = douta;
`endif
          end else begin
            douta_next    = mem[addra];
            rd_valid_next = 1'b1;
          end
        end
      end
      default: begin
        state_next = ST_INIT;
        ptr_next   = '0;
      end
    endcase
  end

  // Array write port; gated by rst so a held reset cannot disturb contents
  always_ff @(posedge clk_g) begin
    if (mem_we && !rst) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign busy = (state == ST_INIT);

endmodule

// File: tb/tb_led_mem_resp.sv
// Scoreboard bench for led_mem_resp: reads push expected words, a negedge monitor pops them on rd_valid.
module tb_led_mem_resp;

  logic        clk_g = 1'b0;
  logic        rst;
  logic        ena;
  logic        wea;
  logic [3:0]  addra;
  logic [15:0] dina;
  logic [15:0] douta;
  logic        busy;
  logic        rd_valid;

  int          checks = 0;
  int          failures = 0;
  logic [15:0] expq [$];
  logic [15:0] mon_word;

  led_mem_resp #(.DATA_W(16), .ADDR_W(4), .INIT_VALUE(16'h0000)) dut (
    .clk_g    (clk_g),
    .rst      (rst),
    .ena      (ena),
    .wea      (wea),
    .addra    (addra),
    .dina     (dina),
    .douta    (douta),
    .busy     (busy),
    .rd_valid (rd_valid)
  );

  always #5 clk_g = ~clk_g;

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Inputs change 1 ns after a rising edge and are captured on the next one
  task automatic applyStimulus(input logic en, input logic we, input logic [3:0] addr, input logic [15:0] data);
    @(posedge clk_g);
    #1;
    ena   = en;
    wea   = we;
    addra = addr;
    dina  = data;
  endtask

  task automatic issueRead(input logic [3:0] addr, input logic [15:0] expected);
    applyStimulus(1'b1, 1'b0, addr, 16'h0000);
    expq.push_back(expected);
  endtask

  task automatic issueWrite(input logic [3:0] addr, input logic [15:0] data);
    applyStimulus(1'b1, 1'b1, addr, data);
  endtask

  task automatic issueIdle();
    applyStimulus(1'b0, 1'b0, 4'h0, 16'h0000);
  endtask

  // Count edges after reset release: busy must stay high through edge 15 and drop on edge 16
  task automatic checkInitWindow(input string tag, input logic drive_requests);
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk_g);
      #1;
      checkOutput({tag, "_busy"}, {15'd0, busy}, (k < 16) ? 16'h0001 : 16'h0000);
      checkOutput({tag, "_douta"}, douta, 16'h0000);
      checkOutput({tag, "_rd_valid"}, {15'd0, rd_valid}, 16'h0000);
      if (k < 16 && drive_requests) begin
        ena   = 1'b1;
        wea   = k[0];
        addra = k[3:0];
        dina  = 16'hDEAD;
      end else begin
        ena = 1'b0;
        wea = 1'b0;
      end
    end
  endtask

  task automatic waitDrain();
    for (int c = 0; c < 50 && expq.size() != 0; c++) begin
      @(posedge clk_g);
    end
    checkOutput("queue_drained", 16'(expq.size()), 16'h0000);
  endtask

  // Monitor: every rd_valid cycle must match the oldest outstanding read
  always @(negedge clk_g) begin
    if (!rst && rd_valid) begin
      if (expq.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_rd_valid: got douta %h, expected no read response at %0t", douta, $time);
      end else begin
        mon_word = expq.pop_front();
        checkOutput("read_data", douta, mon_word);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst   = 1'b1;
    ena   = 1'b1;
    wea   = 1'b0;
    addra = 4'h0;
    dina  = 16'hDEAD;
    #1;
    checkOutput("reset_douta", douta, 16'h0000);
    checkOutput("reset_busy", {15'd0, busy}, 16'h0001);
    checkOutput("reset_rd_valid", {15'd0, rd_valid}, 16'h0000);
    repeat (3) @(posedge clk_g);
    @(negedge clk_g);
    rst = 1'b0;

    // Requests (including writes of DEAD) during init must be dropped
    checkInitWindow("init", 1'b1);

    for (int i = 0; i < 16; i++) begin
      issueRead(i[3:0], 16'h0000);
    end
    issueIdle();
    waitDrain();

    issueWrite(4'd3, 16'hA5A5);
    issueRead(4'd3, 16'hA5A5);

    issueWrite(4'd7, 16'hBEEF);
    issueRead(4'd7, 16'hBEEF);
    issueWrite(4'd7, 16'h1234);
    issueIdle();
`ifdef MEM_WRITE_FIRST_EN
    checkOutput("write_douta", douta, 16'h1234);
`else
    checkOutput("write_douta", douta, 16'hBEEF);
`endif
    checkOutput("write_rd_valid", {15'd0, rd_valid}, 16'h0000);
    issueRead(4'd7, 16'h1234);
    issueIdle();
    waitDrain();

    for (int i = 0; i < 16; i++) begin
      issueWrite(i[3:0], 16'h0001 << i);
    end
    issueRead(4'd5, 16'h0020);
    issueRead(4'd0, 16'h0001);
    issueRead(4'd15, 16'h8000);
    issueIdle();
    waitDrain();

    // Reset mid-stream while a read is pending; the read is discarded
    applyStimulus(1'b1, 1'b0, 4'd9, 16'h0000);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midrst_douta", douta, 16'h0000);
    checkOutput("midrst_busy", {15'd0, busy}, 16'h0001);
    checkOutput("midrst_rd_valid", {15'd0, rd_valid}, 16'h0000);
    ena = 1'b0;
    @(posedge clk_g);
    #3;
    rst = 1'b0;
    checkInitWindow("reinit", 1'b0);

    issueRead(4'd5, 16'h0000);
    issueRead(4'd15, 16'h0000);
    issueIdle();
    waitDrain();

    issueWrite(4'd2, 16'h00FF);
    issueRead(4'd2, 16'h00FF);
    issueIdle();
    for (int c = 0; c < 10; c++) begin
      issueIdle();
      checkOutput("hold_douta", douta, 16'h00FF);
      checkOutput("hold_rd_valid", {15'd0, rd_valid}, 16'h0000);
    end
    waitDrain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
